// File: rtl/tw_gen_seq.sv
// Twiddle generator for an N-point radix-2 DIF FFT: quarter-wave cosine table expanded by quadrant symmetry, with a per-stage sequencer.
// Output appears 3 en-cycles after issue; en=0 freezes sequencer and pipeline, and there is no output backpressure.
module tw_gen_seq #(
    parameter int LOG2N = 6,
    parameter int WIDTH = 12,
    parameter int SW    = $clog2(LOG2N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    start,
    input  logic [SW-1:0]           stage,
    input  logic                    inverse,
    output logic                    busy,
    output logic                    tw_valid,
    output logic                    tw_last,
    output logic signed [WIDTH-1:0] twiddle_re,
    output logic signed [WIDTH-1:0] twiddle_im
);
    localparam int N   = 1 << LOG2N;
    localparam int QTR = N / 4;
    localparam int AMP = (1 << (WIDTH - 1)) - 1;
    localparam int JW  = LOG2N - 1;
    localparam int RW  = LOG2N - 2;
    localparam logic [SW-1:0] SMAX  = SW'(LOG2N - 1);
    localparam logic [JW-1:0] JLAST = {JW{1'b1}};
    localparam logic [RW:0]   QIDX  = (RW + 1)'(QTR);

    // Quarter-wave samples are all non-negative, so +0.5 then truncate rounds half away from zero.
    function automatic logic signed [WIDTH-1:0] qval(input int i);
        real x;
        int  v;
        if (i == 0) begin
            v = AMP;
        end else if (i == QTR) begin
            v = 0;
        end else begin
            x = real'(AMP) * $cos(2.0 * 3.14159265358979323846 * real'(i) / real'(N));
            v = $rtoi(x + 0.5);
        end
        return v[WIDTH-1:0];
    endfunction

    logic signed [WIDTH-1:0] qtab [QTR+1];
    for (genvar gi = 0; gi <= QTR; gi++) begin : g_qtab
        assign qtab[gi] = qval(gi);
    end

    // Sequencer
    logic [SW-1:0]    s_q;
    logic             inv_q;
    logic [JW-1:0]    j_q;
    logic [JW-1:0]    jmask;
    logic [LOG2N-1:0] k_iss;

    // N >> (s+1) is a power of two, so the modulo is a mask of the low bits of j.
    assign jmask = JLAST >> s_q;
    assign k_iss = {1'b0, j_q & jmask} << s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            j_q   <= '0;
            s_q   <= '0;
            inv_q <= 1'b0;
        end else if (en) begin
            if (!busy) begin
                if (start) begin
                    busy  <= 1'b1;
                    j_q   <= '0;
                    s_q   <= (stage > SMAX) ? SMAX : stage;
                    inv_q <= inverse;
                end
            end else begin
                j_q <= j_q + JW'(1);
                if (j_q == JLAST) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    // P1: issued index
    logic             p1_vld;
    logic             p1_inv;
    logic             p1_last;
    logic [LOG2N-1:0] p1_k;

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_vld  <= 1'b0;
            p1_inv  <= 1'b0;
            p1_last <= 1'b0;
            p1_k    <= '0;
        end else if (en) begin
            p1_vld  <= busy;
            p1_inv  <= inv_q;
            p1_last <= busy & (j_q == JLAST);
            p1_k    <= k_iss;
        end
    end

    // P2: table reads
    logic [RW:0] c_idx;
    logic [RW:0] s_idx;
    assign c_idx = {1'b0, p1_k[RW-1:0]};
    assign s_idx = QIDX - c_idx;

    logic                    p2_vld;
    logic                    p2_inv;
    logic                    p2_last;
    logic [1:0]              p2_qd;
    logic signed [WIDTH-1:0] p2_c;
    logic signed [WIDTH-1:0] p2_sn;

    always_ff @(posedge clk) begin
        if (rst) begin
            p2_vld  <= 1'b0;
            p2_inv  <= 1'b0;
            p2_last <= 1'b0;
            p2_qd   <= '0;
            p2_c    <= '0;
            p2_sn   <= '0;
        end else if (en) begin
            p2_vld  <= p1_vld;
            p2_inv  <= p1_inv;
            p2_last <= p1_last;
            p2_qd   <= p1_k[LOG2N-1 -: 2];
            p2_c    <= qtab[c_idx];
            p2_sn   <= qtab[s_idx];
        end
    end

    // P3: quadrant swap/sign and conjugation
    logic signed [WIDTH-1:0] cos_v;
    logic signed [WIDTH-1:0] sin_v;

    always_comb begin
        cos_v = p2_c;
        sin_v = p2_sn;
        case (p2_qd)
            2'd0: begin cos_v = p2_c;   sin_v = p2_sn;  end
            2'd1: begin cos_v = -p2_sn; sin_v = p2_c;   end
            2'd2: begin cos_v = -p2_c;  sin_v = -p2_sn; end
            default: begin cos_v = p2_sn; sin_v = -p2_c; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tw_valid   <= 1'b0;
            tw_last    <= 1'b0;
            twiddle_re <= '0;
            twiddle_im <= '0;
        end else if (en) begin
            tw_valid <= p2_vld;
            tw_last  <= p2_vld & p2_last;
            if (p2_vld) begin
                twiddle_re <= cos_v;
                twiddle_im <= p2_inv ? sin_v : -sin_v;
            end
        end
    end

endmodule

// File: tb/tb_tw_gen_seq.sv
// Bench for tw_gen_seq: trig-model scoreboard per sample, table of known twiddle constants, and hand-written corner sequences.
module tb_tw_gen_seq;
    localparam int  LOG2N = 6;
    localparam int  WIDTH = 12;
    localparam int  SW    = $clog2(LOG2N);
    localparam int  N     = 1 << LOG2N;
    localparam int  HALF  = N / 2;
    localparam int  AMP   = (1 << (WIDTH - 1)) - 1;
    localparam real PI    = 3.14159265358979323846;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic                    start;
    logic [SW-1:0]           stage;
    logic                    inverse;
    logic                    busy;
    logic                    tw_valid;
    logic                    tw_last;
    logic signed [WIDTH-1:0] twiddle_re;
    logic signed [WIDTH-1:0] twiddle_im;

    tw_gen_seq #(.LOG2N(LOG2N), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .stage      (stage),
        .inverse    (inverse),
        .busy       (busy),
        .tw_valid   (tw_valid),
        .tw_last    (tw_last),
        .twiddle_re (twiddle_re),
        .twiddle_im (twiddle_im)
    );

    always #5 clk = ~clk;

    typedef struct {
        int re;
        int im;
        bit last;
    } exp_t;

    typedef struct {
        int run;
        int idx;
        int re;
        int im;
    } vec_t;

    exp_t sb [$];
    vec_t vecs [14];
    int   log_re [$];
    int   log_im [$];
    int   log_cyc [$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   nvalid = 0;
    int   last_cyc = -1;
    int   start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(req));
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    task automatic push_seq(input int s, input bit inv);
        exp_t e;
        int   se;
        int   k;
        int   sv;
        real  a;
        se = (s > LOG2N - 1) ? LOG2N - 1 : s;
        for (int j = 0; j < HALF; j++) begin
            k      = (j % (N >> (se + 1))) << se;
            a      = 2.0 * PI * real'(k) / real'(N);
            sv     = rnd(real'(AMP) * $sin(a));
            e.re   = rnd(real'(AMP) * $cos(a));
            e.im   = inv ? sv : -sv;
            e.last = (j == HALF - 1);
            sb.push_back(e);
        end
    endtask

    // A sample is consumed in a cycle where both tw_valid and en are high.
    task automatic monitor();
        exp_t e;
        if (en === 1'b1 && tw_valid === 1'b1) begin
            nvalid++;
            log_re.push_back(int'(twiddle_re));
            log_im.push_back(int'(twiddle_im));
            log_cyc.push_back(cyc);
            if (tw_last === 1'b1) last_cyc = cyc;
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", 32'(tw_valid), 0);
            end else begin
                e = sb.pop_front();
                check("sb_re", twiddle_re, e.re);
                check("sb_im", twiddle_im, e.im);
                check("sb_last", 32'(tw_last), 32'(e.last));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic reset_logs();
        log_re.delete();
        log_im.delete();
        log_cyc.delete();
        nvalid   = 0;
        last_cyc = -1;
    endtask

    task automatic do_start(input int s, input bit inv);
        stage     = SW'(s);
        inverse   = inv;
        start     = 1'b1;
        en        = 1'b1;
        start_cyc = cyc;
        push_seq(s, inv);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit stall);
        int i;
        i = 0;
        while (!(sb.size() == 0 && busy === 1'b0) && i < 400) begin
            en = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            i++;
        end
        en = 1'b1;
        if (i >= 400) check("wait_timeout", sb.size(), 0);
        repeat (3) tick();
    endtask

    task automatic run_seq(input int run, input int s, input bit inv, input bit stall);
        reset_logs();
        do_start(s, inv);
        wait_done(stall);
        check($sformatf("run%0d_count", run), nvalid, HALF);
        for (int v = 0; v < 14; v++) begin
            if (vecs[v].run == run) begin
                if (vecs[v].idx < log_re.size()) begin
                    check($sformatf("run%0d_re[%0d]", run, vecs[v].idx), log_re[vecs[v].idx], vecs[v].re);
                    check($sformatf("run%0d_im[%0d]", run, vecs[v].idx), log_im[vecs[v].idx], vecs[v].im);
                end else begin
                    check($sformatf("run%0d_missing[%0d]", run, vecs[v].idx), log_re.size(), vecs[v].idx + 1);
                end
            end
        end
    endtask

    initial begin
        int a_start;
        int b_start;
        int i;

        vecs[0]  = '{0, 0, 2047, 0};
        vecs[1]  = '{0, 4, 1891, -783};
        vecs[2]  = '{0, 8, 1447, -1447};
        vecs[3]  = '{0, 16, 0, -2047};
        vecs[4]  = '{0, 24, -1447, -1447};
        vecs[5]  = '{1, 0, 2047, 0};
        vecs[6]  = '{1, 8, 2047, 0};
        vecs[7]  = '{1, 1, 1891, -783};
        vecs[8]  = '{2, 0, 2047, 0};
        vecs[9]  = '{2, 31, 2047, 0};
        vecs[10] = '{3, 0, 2047, 0};
        vecs[11] = '{3, 31, 2047, 0};
        vecs[12] = '{4, 16, 0, 2047};
        vecs[13] = '{4, 8, 1447, 1447};

        rst = 1'b1; en = 1'b1; start = 1'b0; stage = '0; inverse = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_tw_valid", 32'(tw_valid), 0);
        check("rst_tw_last", 32'(tw_last), 0);
        check("rst_re", twiddle_re, 0);
        check("rst_im", twiddle_im, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 0);

        run_seq(0, 0, 1'b0, 1'b0);
        check("lat_first", (log_cyc.size() > 0) ? log_cyc[0] - start_cyc : -1, 4);
        check("lat_last", last_cyc - start_cyc, HALF + 3);
        run_seq(1, 2, 1'b0, 1'b0);
        run_seq(2, 5, 1'b0, 1'b0);
        run_seq(3, 7, 1'b0, 1'b0);
        run_seq(4, 0, 1'b1, 1'b0);
        run_seq(5, 0, 1'b0, 1'b1);

        // Back-to-back: second start in the cycle busy drops; a start while busy must be ignored.
        reset_logs();
        do_start(0, 1'b0);
        a_start = start_cyc;
        i = 0;
        while (busy === 1'b1 && i < 100) begin
            tick();
            i++;
        end
        check("b2b_busy_fall", cyc - a_start, HALF + 1);
        do_start(1, 1'b0);
        b_start = start_cyc;
        check("b2b_busy_again", 32'(busy), 1);
        repeat (5) tick();
        stage = 3'd3; inverse = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0);
        check("b2b_count", nvalid, 2 * HALF);
        check("b2b_second_first", (log_cyc.size() > HALF) ? log_cyc[HALF] - b_start : -1, 4);

        // Abort with rst while issuing j=10.
        reset_logs();
        do_start(0, 1'b0);
        repeat (10) tick();
        check("abort_busy_before", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_tw_valid", 32'(tw_valid), 0);
        check("abort_tw_last", 32'(tw_last), 0);
        sb.delete();
        nvalid = 0;
        repeat (40) tick();
        check("abort_no_valid", nvalid, 0);
        check("abort_idle_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tw_gen_seq.md
Name: tw_gen_seq

Overview:
- Parametrised twiddle-factor generator for an N-point radix-2 DIF FFT. Replaces the per-stage hard-coded twiddle ROMs.
- A quarter-wave cosine table, filled at elaboration, is expanded by quadrant symmetry to the full W_N^k.
- An internal sequencer emits the complete twiddle sequence for any selected stage after a start pulse. It supports forward and inverse (conjugate) mode.
- The output feeds the butterfly multiplier. The pipeline is stalled by the global en.

Parameters:
- LOG2N, 6, log2 of FFT size N (legal range 3..12)
- WIDTH, 12, signed twiddle width; amplitude AMP = 2^(WIDTH-1)-1 (2047 at default)
- SW, $clog2(LOG2N), width of stage port

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  pipeline/sequencer advance enable; 0 freezes all state and outputs
- start  in  1  sequence start pulse
- stage  in  SW  stage index s, sampled on accepted start
- inverse  in  1  1 = conjugate twiddles (IFFT), sampled on accepted start
- busy  out  1  sequencer issuing
- tw_valid  out  1  twiddle outputs valid
- tw_last  out  1  marks the final twiddle of a sequence
- twiddle_re  out  WIDTH signed  real part
- twiddle_im  out  WIDTH signed  imaginary part

Behaviour:
- Table: q[i] = round(AMP*cos(2*pi*i/N)) for i = 0..N/4, rounding half away from zero. q[0] = AMP and q[N/4] = 0 are forced.
- Index split: k = {qd[1:0], r[LOG2N-3:0]}, with c = q[r] and sn = q[N/4 - r].
- Quadrant mapping (cos, sin):
  - qd0: ( c,  sn)
  - qd1: (-sn,  c)
  - qd2: (-c, -sn)
  - qd3: ( sn, -c)
- Outputs: twiddle_re = cos. twiddle_im = -sin when forward, +sin when inverse.
- Negation never overflows, because all magnitudes are ≤ AMP.
- Reset: busy, tw_valid, tw_last, twiddle_re, twiddle_im, the counter j, and all pipeline valids = 0.
- Start acceptance: start=1 & en=1 & busy=0.
  - On acceptance, latch stage and inverse, set j=0, and set busy=1 next cycle.
  - stage ≥ LOG2N is clamped to LOG2N-1.
  - start while busy=1 is ignored. start with en=0 is ignored.
- Issue: each cycle with busy=1 & en=1 issues k = (j mod (N >> (s+1))) << s, then increments j.
  - After issuing j = N/2-1, busy=0 on the next cycle.
  - A new start is acceptable in that cycle (back-to-back sequences; the pipeline drains concurrently).
- Pipeline, 3 registered steps, each advancing only when en=1:
  - P1: k, qd, inv, last.
  - P2: table reads c, sn.
  - P3: swap, sign and conjugate into the output registers.
- Latency: a sample issued in en-cycle t appears on the outputs at en-cycle t+3.
  - Example with no stalls: start at cycle 0, busy from cycle 1, first tw_valid at cycle 4, last (tw_last=1) at cycle N/2+3.
- tw_valid follows the pipeline valid bit. When tw_valid=0 the output values hold their previous contents (don't-care for consumers).
- en=0 mid-sequence: j, busy, and every pipeline register hold. No sample is lost or duplicated.
- rst mid-sequence: immediate abort. All of the above return to reset values on the next edge; the pipeline is flushed.

Test Plan:
- Reset, then start with stage=0, inverse=0, en=1 held (N=64, WIDTH=12) -> 32 valid outputs on cycles 4..35, k=0..31.
  - k=0 -> (2047, 0); k=4 -> (1891, -783); k=8 -> (1447, -1447); k=16 -> (0, -2047); k=24 -> (-1447, -1447).
  - tw_last only on the k=31 output.
- stage=2 -> k sequence 0, 4, ..., 28 repeated 4 times.
  - Outputs 0 and 8 = (2047, 0); output 1 = (1891, -783).
- stage=5, and separately stage=7 (clamped) -> all 32 outputs (2047, 0).
- inverse=1, stage=0 -> k=16 gives (0, +2047); k=8 gives (1447, +1447).
- Random en deassertion during a sequence -> the output stream equals the no-stall stream in order, with exactly 32 tw_valid samples.
- Start in the cycle busy falls -> the second sequence follows with no gap. A start while busy is ignored. rst asserted at issue j=10 -> busy=0 and tw_valid=0 on the next cycle, and no further valid outputs.
